// File: rtl/commit_trace_buffer.sv
// ============================================================================
// Module   : commit_trace_buffer
// Purpose  : Captures one cpu commit record per cycle into a FIFO and
//            serializes each record onto a 32-bit valid/ready trace stream.
//            Every commit is numbered; records dropped while the FIFO is full
//            are counted and flagged on the next stored record.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                in   clock, all state updates on posedge
//   rst                in   asynchronous reset, active-low
//   commit_valid       in   one instruction commits this cycle
//   commit_pc          in   [31:0] pc of the committing instruction
//   commit_inst        in   [31:0] instruction word
//   commit_rd_addr     in   [4:0]  destination register, 0 = no writeback
//   commit_rd_wdata    in   [31:0] writeback value
//   commit_mem_addr    in   [31:0] data memory address
//   commit_mem_rmask   in   [3:0]  byte read mask
//   commit_mem_wmask   in   [3:0]  byte write mask
//   tx_valid           out  tx_data holds a valid word
//   tx_ready           in   sink accepts the word
//   tx_data            out  [31:0] serialized record word
//   tx_last            out  final word of the current record
//   overflow           out  sticky, at least one record was dropped
//   drop_count         out  [15:0] dropped records, saturating
// ============================================================================
`default_nettype none

module commit_trace_buffer #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        commit_valid,
   input  logic [31:0] commit_pc,
   input  logic [31:0] commit_inst,
   input  logic [4:0]  commit_rd_addr,
   input  logic [31:0] commit_rd_wdata,
   input  logic [31:0] commit_mem_addr,
   input  logic [3:0]  commit_mem_rmask,
   input  logic [3:0]  commit_mem_wmask,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [31:0] tx_data,
   output logic        tx_last,
   output logic        overflow,
   output logic [15:0] drop_count
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_W0   = 3'd1,
      S_W1   = 3'd2,
      S_W2   = 3'd3,
      S_W3   = 3'd4,
      S_W4   = 3'd5
   } state_t;

   // Record storage (no reset needed: contents are only read when count > 0)
   logic [31:0] pc_q    [DEPTH];
   logic [31:0] inst_q  [DEPTH];
   logic [4:0]  rd_q    [DEPTH];
   logic [31:0] wdata_q [DEPTH];
   logic [31:0] maddr_q [DEPTH];
   logic [3:0]  rmask_q [DEPTH];
   logic [3:0]  wmask_q [DEPTH];
   logic [15:0] seq_q   [DEPTH];
   logic        gap_q   [DEPTH];

   state_t        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic [15:0]   seq_cnt_q;
   logic          pending_gap_q;
   logic          overflow_q;
   logic [15:0]   drop_count_q;

   logic          full;
   logic          xfer;
   logic          pop;
   logic          push;
   logic          drop;
   logic          head_mem;
   logic [31:0]   wdata_in;

   assign full     = (count_q == FULL_CNT);
   assign head_mem = |(rmask_q[rd_ptr_q] | wmask_q[rd_ptr_q]);
   assign xfer     = tx_valid && tx_ready;
   assign pop      = xfer && tx_last;
   // A pop on the same edge frees the slot, so a full FIFO can still accept.
   assign push     = commit_valid && (!full || pop);
   assign drop     = commit_valid && full && !pop;
   assign wdata_in = (commit_rd_addr == 5'd0) ? 32'd0 : commit_rd_wdata;

   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;

   // ---------------------------------------------------------------- storage
   always_ff @(posedge clk) begin
      if (push) begin
         pc_q[wr_ptr_q]    <= commit_pc;
         inst_q[wr_ptr_q]  <= commit_inst;
         rd_q[wr_ptr_q]    <= commit_rd_addr;
         wdata_q[wr_ptr_q] <= wdata_in;
         maddr_q[wr_ptr_q] <= commit_mem_addr;
         rmask_q[wr_ptr_q] <= commit_mem_rmask;
         wmask_q[wr_ptr_q] <= commit_mem_wmask;
         seq_q[wr_ptr_q]   <= seq_cnt_q;
         gap_q[wr_ptr_q]   <= pending_gap_q;
      end
   end

   // ------------------------------------------------------ occupancy update
   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + (AW+1)'(1);
      end else if (pop && !push) begin
         count_d = count_q - (AW+1)'(1);
      end
   end

   // ------------------------------------------- word-index FSM and tx mux
   always_comb begin
      state_d  = state_q;
      tx_valid = 1'b0;
      tx_data  = 32'd0;
      tx_last  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (push) begin
               state_d = S_W0;
            end
         end
         S_W0: begin
            tx_valid = 1'b1;
            tx_data  = pc_q[rd_ptr_q];
            if (xfer) state_d = S_W1;
         end
         S_W1: begin
            tx_valid = 1'b1;
            tx_data  = inst_q[rd_ptr_q];
            if (xfer) state_d = S_W2;
         end
         S_W2: begin
            tx_valid = 1'b1;
            tx_data  = {rmask_q[rd_ptr_q], wmask_q[rd_ptr_q], gap_q[rd_ptr_q],
                        2'b00, rd_q[rd_ptr_q], seq_q[rd_ptr_q]};
            if (xfer) state_d = S_W3;
         end
         S_W3: begin
            tx_valid = 1'b1;
            tx_data  = wdata_q[rd_ptr_q];
            tx_last  = !head_mem;
            if (xfer) begin
               if (head_mem) begin
                  state_d = S_W4;
               end else begin
                  state_d = (count_d != '0) ? S_W0 : S_IDLE;
               end
            end
         end
         S_W4: begin
            tx_valid = 1'b1;
            tx_data  = maddr_q[rd_ptr_q];
            tx_last  = 1'b1;
            if (xfer) begin
               state_d = (count_d != '0) ? S_W0 : S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------- control state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         seq_cnt_q     <= 16'd0;
         pending_gap_q <= 1'b0;
         overflow_q    <= 1'b0;
         drop_count_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         // Numbering counts every commit, stored or dropped, so gaps show up
         // as jumps in the sequence seen by the sink.
         if (commit_valid) begin
            seq_cnt_q <= seq_cnt_q + 16'd1;
         end
         if (drop) begin
            pending_gap_q <= 1'b1;
            overflow_q    <= 1'b1;
            if (drop_count_q != 16'hFFFF) begin
               drop_count_q <= drop_count_q + 16'd1;
            end
         end else if (push) begin
            pending_gap_q <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_buffer.sv
`default_nettype none

module tb_commit_trace_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        commit_valid;
   logic [31:0] commit_pc;
   logic [31:0] commit_inst;
   logic [4:0]  commit_rd_addr;
   logic [31:0] commit_rd_wdata;
   logic [31:0] commit_mem_addr;
   logic [3:0]  commit_mem_rmask;
   logic [3:0]  commit_mem_wmask;
   logic        tx_valid;
   logic        tx_ready;
   logic [31:0] tx_data;
   logic        tx_last;
   logic        overflow;
   logic [15:0] drop_count;

   always #5 clk = ~clk;

   commit_trace_buffer #(.DEPTH(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .commit_valid     (commit_valid),
      .commit_pc        (commit_pc),
      .commit_inst      (commit_inst),
      .commit_rd_addr   (commit_rd_addr),
      .commit_rd_wdata  (commit_rd_wdata),
      .commit_mem_addr  (commit_mem_addr),
      .commit_mem_rmask (commit_mem_rmask),
      .commit_mem_wmask (commit_mem_wmask),
      .tx_valid         (tx_valid),
      .tx_ready         (tx_ready),
      .tx_data          (tx_data),
      .tx_last          (tx_last),
      .overflow         (overflow),
      .drop_count       (drop_count)
   );

   typedef struct packed {
      logic [31:0]       pc;
      logic [31:0]       inst;
      logic [4:0]        rd;
      logic [31:0]       wdata;
      logic [31:0]       maddr;
      logic [3:0]        rm;
      logic [3:0]        wm;
      logic [4:0][31:0]  w;
      logic [2:0]        n;
   } vec_t;

   vec_t        vecs [5];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_w [5];
   int          exp_n;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic set_model(input logic [31:0] pc, input logic [31:0] inst,
                            input logic [4:0] rd, input logic [31:0] wdata,
                            input logic [31:0] maddr, input logic [3:0] rm,
                            input logic [3:0] wm, input logic [15:0] seq,
                            input logic gap);
      exp_w[0] = pc;
      exp_w[1] = inst;
      exp_w[2] = {rm, wm, gap, 2'b00, rd, seq};
      exp_w[3] = (rd == 5'd0) ? 32'd0 : wdata;
      exp_w[4] = maddr;
      exp_n    = ((rm | wm) != 4'd0) ? 5 : 4;
   endtask

   task automatic drive_commit(input logic [31:0] pc, input logic [31:0] inst,
                               input logic [4:0] rd, input logic [31:0] wdata,
                               input logic [31:0] maddr, input logic [3:0] rm,
                               input logic [3:0] wm);
      commit_valid     = 1'b1;
      commit_pc        = pc;
      commit_inst      = inst;
      commit_rd_addr   = rd;
      commit_rd_wdata  = wdata;
      commit_mem_addr  = maddr;
      commit_mem_rmask = rm;
      commit_mem_wmask = wm;
   endtask

   // One commit cycle. With chk_lat the FIFO is expected empty beforehand:
   // no tx before the capturing edge, W0 right after it.
   task automatic commit_one(input logic [31:0] pc, input logic [31:0] inst,
                             input logic [4:0] rd, input logic [31:0] wdata,
                             input logic [31:0] maddr, input logic [3:0] rm,
                             input logic [3:0] wm, input bit chk_lat);
      @(negedge clk);
      drive_commit(pc, inst, rd, wdata, maddr, rm, wm);
      if (chk_lat) begin
         #1;
         chk("no_bypass_valid", {31'd0, tx_valid}, 32'd0);
      end
      @(posedge clk);
      #1;
      commit_valid = 1'b0;
      if (chk_lat) begin
         chk("latency_valid", {31'd0, tx_valid}, 32'd1);
         chk("latency_w0", tx_data, pc);
      end
   endtask

   // Receive exp_n words of exp_w. Without rnd, tx_ready is held high and
   // tx_valid must be present every cycle (no idle gaps).
   task automatic recv(input string name, input bit rnd);
      int idx    = 0;
      int budget = 400;
      while (idx < exp_n && budget > 0) begin
         @(negedge clk);
         tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (!rnd) chk({name, "_valid"}, {31'd0, tx_valid}, 32'd1);
         if (tx_valid) begin
            chk({name, "_data"}, tx_data, exp_w[idx]);
            chk({name, "_last"}, {31'd0, tx_last}, {31'd0, (idx == exp_n - 1)});
            if (tx_ready) idx++;
         end
         budget--;
      end
      if (idx < exp_n) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_timeout: got %0d words expected %0d", name, idx, exp_n);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst          = 1'b0;
      commit_valid = 1'b0;
      tx_ready     = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // pc, inst, rd, wdata, maddr, rm, wm, {W4..W0}, n
      vecs[0] = '{32'h60000000, 32'h00500093, 5'd1, 32'h5, 32'h0, 4'h0, 4'h0,
                  {32'h0, 32'h00000005, 32'h00010000, 32'h00500093, 32'h60000000}, 3'd4};
      vecs[1] = '{32'h60000004, 32'h0000A023, 5'd0, 32'hDEAD, 32'h60001000, 4'h0, 4'hF,
                  {32'h60001000, 32'h0, 32'h0F000001, 32'h0000A023, 32'h60000004}, 3'd5};
      vecs[2] = '{32'h60000008, 32'h0000A183, 5'd3, 32'h12345678, 32'h60001004, 4'hF, 4'h0,
                  {32'h60001004, 32'h12345678, 32'hF0030002, 32'h0000A183, 32'h60000008}, 3'd5};
      vecs[3] = '{32'h6000000C, 32'h00108023, 5'd0, 32'hFFFF, 32'h60001001, 4'h0, 4'h2,
                  {32'h60001001, 32'h0, 32'h02000003, 32'h00108023, 32'h6000000C}, 3'd5};
      vecs[4] = '{32'h60000010, 32'hCAFE0FB7, 5'd31, 32'hCAFEBABE, 32'h12345678, 4'h0, 4'h0,
                  {32'h0, 32'hCAFEBABE, 32'h001F0004, 32'hCAFE0FB7, 32'h60000010}, 3'd4};

      rst              = 1'b0;
      commit_valid     = 1'b0;
      commit_pc        = '0;
      commit_inst      = '0;
      commit_rd_addr   = '0;
      commit_rd_wdata  = '0;
      commit_mem_addr  = '0;
      commit_mem_rmask = '0;
      commit_mem_wmask = '0;
      tx_ready         = 1'b0;

      // Reset state
      do_reset();
      #1;
      chk("rst_valid", {31'd0, tx_valid}, 32'd0);
      chk("rst_data", tx_data, 32'd0);
      chk("rst_last", {31'd0, tx_last}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      chk("rst_drop_count", {16'd0, drop_count}, 32'd0);

      // Directed single records, sequence numbers 0..4
      for (int i = 0; i < 5; i++) begin
         commit_one(vecs[i].pc, vecs[i].inst, vecs[i].rd, vecs[i].wdata,
                    vecs[i].maddr, vecs[i].rm, vecs[i].wm, 1'b1);
         for (int k = 0; k < 5; k++) exp_w[k] = vecs[i].w[k];
         exp_n = int'(vecs[i].n);
         recv($sformatf("vec%0d", i), 1'b0);
      end

      // Overflow: 10 commits into a stalled sink, 8 stored, 2 dropped
      do_reset();
      for (int i = 0; i < 10; i++) begin
         commit_one(32'h60000100 + 32'(4 * i), 32'h13, 5'(i + 1), 32'(i),
                    32'h0, 4'h0, 4'h0, 1'b0);
      end
      @(negedge clk);
      #1;
      chk("ovf_overflow", {31'd0, overflow}, 32'd1);
      chk("ovf_drop_count", {16'd0, drop_count}, 32'd2);
      chk("ovf_stall_w0", tx_data, 32'h60000100);
      for (int i = 0; i < 8; i++) begin
         set_model(32'h60000100 + 32'(4 * i), 32'h13, 5'(i + 1), 32'(i),
                   32'h0, 4'h0, 4'h0, 16'(i), 1'b0);
         recv($sformatf("ovf_rec%0d", i), 1'b0);
      end
      commit_one(32'h60000200, 32'h13, 5'd5, 32'h55, 32'h0, 4'h0, 4'h0, 1'b1);
      exp_w[0] = 32'h60000200;
      exp_w[1] = 32'h00000013;
      exp_w[2] = 32'h0085000A;
      exp_w[3] = 32'h00000055;
      exp_n    = 4;
      recv("gap_rec", 1'b0);
      chk("gap_overflow_sticky", {31'd0, overflow}, 32'd1);
      chk("gap_drop_count", {16'd0, drop_count}, 32'd2);

      // Full FIFO: push coincides with a tx_last pop
      do_reset();
      for (int i = 0; i < 8; i++) begin
         commit_one(32'h60000300 + 32'(4 * i), 32'h13, 5'(i + 1), 32'h100 + 32'(i),
                    32'h0, 4'h0, 4'h0, 1'b0);
      end
      set_model(32'h60000300, 32'h13, 5'd1, 32'h100, 32'h0, 4'h0, 4'h0, 16'd0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         tx_ready = 1'b1;
         #1;
         chk($sformatf("full_w%0d", k), tx_data, exp_w[k]);
      end
      @(negedge clk);
      drive_commit(32'h60000320, 32'h13, 5'd9, 32'h108, 32'h0, 4'h0, 4'h0);
      tx_ready = 1'b1;
      #1;
      chk("full_w3_last", {31'd0, tx_last}, 32'd1);
      chk("full_w3_data", tx_data, exp_w[3]);
      @(posedge clk);
      #1;
      commit_valid = 1'b0;
      tx_ready     = 1'b0;
      chk("full_swap_drop_count", {16'd0, drop_count}, 32'd0);
      chk("full_swap_overflow", {31'd0, overflow}, 32'd0);
      commit_one(32'h60000324, 32'h13, 5'd10, 32'h109, 32'h0, 4'h0, 4'h0, 1'b0);
      @(negedge clk);
      #1;
      chk("full_still_full_drop", {16'd0, drop_count}, 32'd1);
      chk("full_still_full_ovf", {31'd0, overflow}, 32'd1);
      for (int i = 1; i < 9; i++) begin
         set_model(32'h60000300 + 32'(4 * i), 32'h13, 5'(i + 1), 32'h100 + 32'(i),
                   32'h0, 4'h0, 4'h0, 16'(i), 1'b0);
         recv($sformatf("full_rec%0d", i), 1'b0);
      end
      @(negedge clk);
      #1;
      chk("full_drained_valid", {31'd0, tx_valid}, 32'd0);

      // Random backpressure across 5-word records
      do_reset();
      commit_one(32'h60000400, 32'h0041A283, 5'd5, 32'hA5A5A5A5, 32'h60002000,
                 4'hF, 4'h0, 1'b1);
      commit_one(32'h60000404, 32'h0051A223, 5'd0, 32'h1, 32'h60002004,
                 4'h0, 4'hF, 1'b0);
      exp_w[0] = 32'h60000400;
      exp_w[1] = 32'h0041A283;
      exp_w[2] = 32'hF0050000;
      exp_w[3] = 32'hA5A5A5A5;
      exp_w[4] = 32'h60002000;
      exp_n    = 5;
      recv("rnd_recA", 1'b1);
      exp_w[0] = 32'h60000404;
      exp_w[1] = 32'h0051A223;
      exp_w[2] = 32'h0F000001;
      exp_w[3] = 32'h00000000;
      exp_w[4] = 32'h60002004;
      exp_n    = 5;
      recv("rnd_recB", 1'b1);
      @(negedge clk);
      tx_ready = 1'b0;
      #1;
      chk("rnd_drained_valid", {31'd0, tx_valid}, 32'd0);

      // Asynchronous reset in the middle of W2
      do_reset();
      for (int i = 0; i < 9; i++) begin
         commit_one(32'h60000500 + 32'(4 * i), 32'h13, 5'd1, 32'(i),
                    32'h0, 4'h0, 4'h0, 1'b0);
      end
      @(negedge clk);
      tx_ready = 1'b1;
      repeat (2) @(negedge clk);
      tx_ready = 1'b0;
      #1;
      chk("mid_w2_data", tx_data, 32'h00010000);
      chk("mid_overflow", {31'd0, overflow}, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_valid", {31'd0, tx_valid}, 32'd0);
      chk("async_rst_data", tx_data, 32'd0);
      chk("async_rst_last", {31'd0, tx_last}, 32'd0);
      chk("async_rst_overflow", {31'd0, overflow}, 32'd0);
      chk("async_rst_drop", {16'd0, drop_count}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("post_rst_empty", {31'd0, tx_valid}, 32'd0);
      commit_one(32'h60000600, 32'h13, 5'd2, 32'h7, 32'h0, 4'h0, 4'h0, 1'b1);
      exp_w[0] = 32'h60000600;
      exp_w[1] = 32'h00000013;
      exp_w[2] = 32'h00020000;
      exp_w[3] = 32'h00000007;
      exp_n    = 4;
      recv("post_rst_rec", 1'b0);
      chk("post_rst_overflow", {31'd0, overflow}, 32'd0);
      chk("post_rst_drop", {16'd0, drop_count}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
